in_line_packer: RTL
===================

# in_line_packer

Write-side front end of the decoder input path: accepts narrow compressed-bitstream words from the host interface and packs them into DATA_WIDTH-wide lines with a start-of-frame flag. Output feeds the write port of the input clock-crossing line buffer (`in_data`/`in_valid`/`in_sof`, no backpressure). Runs entirely in the input (write) clock domain. Handles frame start/end alignment, zero-padding of partial lines and truncated-frame detection.

## Interface
- IN_WIDTH, 32, input word width in bits
- DATA_WIDTH, 256, output line width in bits; DATA_WIDTH/IN_WIDTH = RATIO must be an integer power of 2, ≥ 2
- clk  input  1  single clock, the input (write) clock domain
- rst_n  input  1  reset, synchronous, active-low
- in_data  input  IN_WIDTH  bitstream word
- in_valid  input  1  word valid; every valid word is accepted (no ready)
- in_sof  input  1  first word of a frame; qualified by in_valid
- in_eof  input  1  last word of a frame; qualified by in_valid
- out_data  output  DATA_WIDTH  packed line
- out_valid  output  1  line valid, one-cycle pulse per line
- out_sof  output  1  line holds the first word of a frame; qualified by out_valid
- out_frame_err  output  1  one-cycle pulse: a frame was truncated by a new in_sof

## Operation
- Word order: first word of a line in bits [IN_WIDTH-1:0], word k in bits [(k+1)*IN_WIDTH-1:k*IN_WIDTH]. Unfilled slots of an emitted line are zero.
- Internal state: line register, slot counter cnt (0..RATIO-1, $clog2(RATIO) bits), sof_pending flag, FSM {IDLE, PACK}.
- IDLE: valid words without in_sof are dropped; in_eof alone ignored. in_valid & in_sof -> word to slot 0, cnt=1, sof_pending=1, go PACK. If in_eof also set (single-word frame) -> emit line immediately with out_sof=1, stay IDLE.
- PACK, in_valid & ~in_sof: word to slot cnt. If cnt==RATIO-1 or in_eof -> emit line with out_sof=sof_pending, clear sof_pending, cnt=0, line register cleared. in_eof -> go IDLE; else cnt+1.
- PACK, in_valid & in_sof: if cnt≠0 -> emit pending partial line (zero-padded, out_sof=sof_pending) and pulse out_frame_err; in the same cycle the new word starts a fresh line at slot 0, cnt=1, sof_pending=1. If cnt==0 -> start fresh line, no error. in_eof with it -> also emit the fresh line; but two lines cannot leave in one cycle: in that case the truncated line is emitted this cycle and the single-word line is held and emitted the next cycle (one-entry hold register), FSM to IDLE.
- No in_valid: state holds; no output.
- Emission is the only producer of out_valid; out_valid never asserts without a preceding accepted word.

## Timing
- Reset (rst_n low at a clk edge): out_data=0, out_valid=0, out_sof=0, out_frame_err=0, cnt=0, sof_pending=0, hold register empty, FSM=IDLE. Reset mid-frame discards the partial line with no output.
- Latency: line completed by the word accepted at edge N appears with out_valid=1 after edge N+1 for exactly one cycle.
- Sustained throughput: one line every RATIO accepted words; gap-free input yields out_valid once every RATIO cycles.
- out_frame_err is coincident with out_valid of the truncated line.
- Held single-word line (sof+eof after truncation): out_valid high two consecutive cycles.

## Structure
- Flat module, no sub-module; RATIO and counter width as localparams derived from parameters. No shared package: the block adds no types used elsewhere.
- Parameter legality (RATIO power of 2, ≥2) checked in an initial block with $error under simulation.

## Test plan
- Reset then 8 words 0x00000001..0x00000008, first with in_sof, back-to-back -> one out_valid, out_sof=1, out_data=0x00000008_..._00000001, one cycle after 8th word.
- 11-word frame, sof on word 1, eof on word 11 -> line 1 out_sof=1 full; line 2 out_sof=0 with words 9..11 in slots 0..2, slots 3..7 zero; FSM back to IDLE.
- 3 words without sof after reset, then normal frame -> first 3 dropped, output identical to scenario 1.
- 5 words of frame A then in_sof for frame B -> partial A line (5 words, out_sof=1) with out_frame_err=1; B lines follow correctly with out_sof on its first line.
- Single word with in_sof & in_eof in IDLE -> one line, out_sof=1, word in slot 0, rest zero; and after a 2-word partial frame -> two consecutive out_valid cycles, err on the first.
- rst_n low for one cycle after 4 words of a frame -> no output, all outputs 0; next sof frame packs from slot 0.

Source files
------------

// File: rtl/in_line_packer.sv
// in_line_packer
// Write-side front end of the decoder input path. Packs narrow bitstream
// words into DATA_WIDTH-wide lines tagged with a start-of-frame flag, zero-pads
// partial lines at frame end, and flags frames cut short by a new start word.
// Output feeds a line buffer write port with no backpressure.
module in_line_packer #(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  in_eof,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_frame_err
);

    localparam int RATIO = DATA_WIDTH / IN_WIDTH;
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PACK = 1'b1
    } state_t;

    // Reject illegal width combinations at elaboration time.
    if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) || (RATIO * IN_WIDTH != DATA_WIDTH)) begin : g_param_err
        $error("in_line_packer: DATA_WIDTH/IN_WIDTH must be an integer power of 2, >= 2");
    end

    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   line_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    sof_pending_r;
    logic                    hold_valid_r;
    logic [IN_WIDTH-1:0]     hold_word_r;

    // First output stage: line captured the same edge the completing word is accepted.
    logic [DATA_WIDTH-1:0]   em_data_r;
    logic                    em_valid_r;
    logic                    em_sof_r;
    logic                    em_err_r;

    // Second output stage drives the ports.
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    out_valid_r;
    logic                    out_sof_r;
    logic                    out_frame_err_r;

    logic [DATA_WIDTH-1:0]   line_ins_s;
    logic [DATA_WIDTH-1:0]   word_line_s;
    logic [DATA_WIDTH-1:0]   hold_line_s;

    // Current line with the incoming word placed at slot cnt; lone words zero-extended.
    always_comb begin
        line_ins_s = line_r;
        line_ins_s[int'(cnt_r) * IN_WIDTH +: IN_WIDTH] = in_data;
        word_line_s = {{(DATA_WIDTH - IN_WIDTH){1'b0}}, in_data};
        hold_line_s = {{(DATA_WIDTH - IN_WIDTH){1'b0}}, hold_word_r};
    end

    // Packing FSM: slot counter, frame flags, hold register and line emission.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            line_r        <= {DATA_WIDTH{1'b0}};
            cnt_r         <= CNT_ZERO;
            sof_pending_r <= 1'b0;
            hold_valid_r  <= 1'b0;
            hold_word_r   <= {IN_WIDTH{1'b0}};
            em_data_r     <= {DATA_WIDTH{1'b0}};
            em_valid_r    <= 1'b0;
            em_sof_r      <= 1'b0;
            em_err_r      <= 1'b0;
        end else begin
            em_data_r    <= {DATA_WIDTH{1'b0}};
            em_valid_r   <= 1'b0;
            em_sof_r     <= 1'b0;
            em_err_r     <= 1'b0;
            hold_valid_r <= 1'b0;

            // A held single-word line always leaves first; it only exists in IDLE.
            if (hold_valid_r) begin
                em_data_r  <= hold_line_s;
                em_valid_r <= 1'b1;
                em_sof_r   <= 1'b1;
            end else begin
                em_err_r   <= 1'b0;
            end

            if (in_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        if (in_sof) begin
                            if (in_eof) begin
                                // Single-word frame; defer it if the output slot is taken.
                                if (hold_valid_r) begin
                                    hold_valid_r <= 1'b1;
                                    hold_word_r  <= in_data;
                                end else begin
                                    em_data_r  <= word_line_s;
                                    em_valid_r <= 1'b1;
                                    em_sof_r   <= 1'b1;
                                end
                            end else begin
                                line_r        <= word_line_s;
                                cnt_r         <= CNT_ONE;
                                sof_pending_r <= 1'b1;
                                state_r       <= ST_PACK;
                            end
                        end else begin
                            // Words outside a frame are dropped.
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_PACK: begin
                        if (!in_sof) begin
                            if ((cnt_r == CNT_LAST) || in_eof) begin
                                em_data_r     <= line_ins_s;
                                em_valid_r    <= 1'b1;
                                em_sof_r      <= sof_pending_r;
                                line_r        <= {DATA_WIDTH{1'b0}};
                                cnt_r         <= CNT_ZERO;
                                sof_pending_r <= 1'b0;
                                if (in_eof) begin
                                    state_r <= ST_IDLE;
                                end else begin
                                    state_r <= ST_PACK;
                                end
                            end else begin
                                line_r <= line_ins_s;
                                cnt_r  <= cnt_r + CNT_ONE;
                            end
                        end else begin
                            // New frame start: flush any partial line as truncated.
                            if (cnt_r != CNT_ZERO) begin
                                em_data_r  <= line_r;
                                em_valid_r <= 1'b1;
                                em_sof_r   <= sof_pending_r;
                                em_err_r   <= 1'b1;
                            end else begin
                                em_err_r   <= 1'b0;
                            end
                            if (in_eof) begin
                                if (cnt_r != CNT_ZERO) begin
                                    hold_valid_r <= 1'b1;
                                    hold_word_r  <= in_data;
                                end else begin
                                    em_data_r  <= word_line_s;
                                    em_valid_r <= 1'b1;
                                    em_sof_r   <= 1'b1;
                                end
                                line_r        <= {DATA_WIDTH{1'b0}};
                                cnt_r         <= CNT_ZERO;
                                sof_pending_r <= 1'b0;
                                state_r       <= ST_IDLE;
                            end else begin
                                line_r        <= word_line_s;
                                cnt_r         <= CNT_ONE;
                                sof_pending_r <= 1'b1;
                                state_r       <= ST_PACK;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r      <= {DATA_WIDTH{1'b0}};
            out_valid_r     <= 1'b0;
            out_sof_r       <= 1'b0;
            out_frame_err_r <= 1'b0;
        end else begin
            out_data_r      <= em_data_r;
            out_valid_r     <= em_valid_r;
            out_sof_r       <= em_sof_r;
            out_frame_err_r <= em_err_r;
        end
    end

    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign out_sof       = out_sof_r;
    assign out_frame_err = out_frame_err_r;

endmodule
